pid_reg_writer: RTL

//   Host-side initiator for the PID controller's register/iterate interface.
//   - Queues coefficient writes and drives the PID's active-low write strobe, reg_addr and reg_data.
//   - Owns iterate_enable: stops the loop, drains the in-flight iteration, applies the writes,

---
 rtl/pid_pkg.sv | 18 +
 rtl/pid_cmd_fifo.sv | 71 +++++++
 rtl/pid_reg_writer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pid_pkg.sv
// Shared types for the PID register writer: controller states, queued command format
// and the default bus width.
package pid_pkg;

    localparam int PID_D_WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, SETTLE} pid_wr_state_t;

    typedef struct packed {
        logic [PID_D_WIDTH_DEFAULT-1:0] addr;
        logic [PID_D_WIDTH_DEFAULT-1:0] data;
    } pid_wr_cmd_t;

    function automatic logic is_busy(input pid_wr_state_t s);
        return (s == DRAIN) || (s == WRITE) || (s == SETTLE);
    endfunction

endpackage

// File: rtl/pid_cmd_fifo.sv
// Synchronous command queue for pid_reg_writer. The ready flag is registered; pushes
// are refused while full even if a pop happens in the same cycle.
module pid_cmd_fifo
    import pid_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  pid_wr_cmd_t             i_data,
    output pid_wr_cmd_t             o_data,
    output logic                    o_ready,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    pid_wr_cmd_t     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_ready;
    logic            r_empty;
    logic            w_push;
    logic            w_pop;
    logic [AW:0]     w_count_next;

    assign w_push = i_push && r_ready;
    assign w_pop  = i_pop && !r_empty;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_next = r_count - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_ready <= (w_count_next != FULL_CNT);
            r_empty <= (w_count_next == '0);
        end
    end

    // NOTE: storage is left unreset; pointers and the empty flag guard every read.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_ready = r_ready;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/pid_reg_writer.sv
// Host-side writer for the PID register bus: gates iterate_enable, drains the running
// iteration, then replays queued writes. Optional shadow filtering via PID_WR_SHADOW_EN.
module pid_reg_writer
    import pid_pkg::*;
#(
    parameter int D_WIDTH       = PID_D_WIDTH_DEFAULT,
    parameter int NUM_REGS      = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int DRAIN_TIMEOUT = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [D_WIDTH-1:0] cmd_addr,
    input  logic [D_WIDTH-1:0] cmd_data,
    input  logic               run_request,
    input  logic               out_valid,
    output logic               write_enable,
    output logic [D_WIDTH-1:0] reg_addr,
    output logic [D_WIDTH-1:0] reg_data,
    output logic               iterate_enable,
    output logic               busy,
    output logic               addr_err,
    output logic               drain_timeout_err,
    input  logic               err_clear
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int DCW = $clog2(DRAIN_TIMEOUT);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DCW-1:0]     DRAIN_LAST  = DCW'(DRAIN_TIMEOUT - 1);
    localparam logic [SCW-1:0]     SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [D_WIDTH-1:0] ADDR_LIMIT  = D_WIDTH'(NUM_REGS);

    pid_wr_state_t    r_state, w_next_state;
    logic [DCW-1:0]   r_drain_cnt;
    logic [SCW-1:0]   r_settle_cnt;
    logic             r_we, r_iter, r_busy, r_addr_err, r_tmo_err;
    logic [D_WIDTH-1:0] r_addr, r_data;

    pid_wr_cmd_t      w_cmd_in, w_head;
    logic             w_ready, w_empty, w_push, w_pop;
    logic [CW-1:0]    w_count;
    logic             w_in_range, w_hit, w_strobe, w_addr_bad, w_timeout;

    assign w_cmd_in = '{addr: cmd_addr, data: cmd_data};
    assign w_push   = cmd_valid && w_ready;
    assign w_pop    = (r_state == WRITE) && !w_empty;

    pid_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (cmd_valid),
        .i_pop   (w_pop),
        .i_data  (w_cmd_in),
        .o_data  (w_head),
        .o_ready (w_ready),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_in_range = (w_head.addr < ADDR_LIMIT);

`ifdef PID_WR_SHADOW_EN
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    logic [D_WIDTH-1:0]  r_shadow [NUM_REGS];
    logic [NUM_REGS-1:0] r_shadow_vld;
    logic [IW-1:0]       w_idx;

    assign w_idx = w_head.addr[IW-1:0];
    assign w_hit = w_in_range && r_shadow_vld[w_idx] && (r_shadow[w_idx] == w_head.data);

    always_ff @(posedge clock) begin
        if (reset)         r_shadow_vld <= '0;
        else if (w_strobe) r_shadow_vld[w_idx] <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (w_strobe) r_shadow[w_idx] <= w_head.data;
    end
`else
    assign w_hit = 1'b0;
`endif

    assign w_strobe   = w_pop && w_in_range && !w_hit;
    assign w_addr_bad = w_pop && !w_in_range;
    assign w_timeout  = (r_state == DRAIN) && (r_drain_cnt == DRAIN_LAST) && !out_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:   if (!w_empty)                            w_next_state = WRITE;
                    else if (run_request)                    w_next_state = RUN;
            RUN:    if (!w_empty || w_push || !run_request)  w_next_state = DRAIN;
            DRAIN:  if (out_valid || r_drain_cnt == DRAIN_LAST)
                        w_next_state = w_empty ? IDLE : WRITE;
            // Leave only once the FIFO is really drained, counting a same-cycle push.
            WRITE:  if (w_empty || (w_count == CW'(1) && !w_push))
                        w_next_state = SETTLE;
            SETTLE: if (w_push || !w_empty)                  w_next_state = WRITE;
                    else if (r_settle_cnt == SETTLE_LAST)    w_next_state = IDLE;
            default:                                         w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_drain_cnt  <= '0;
            r_settle_cnt <= '0;
            r_we         <= 1'b1;
            r_addr       <= '0;
            r_data       <= '0;
            r_iter       <= 1'b0;
            r_busy       <= 1'b0;
            r_addr_err   <= 1'b0;
            r_tmo_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state != DRAIN)              r_drain_cnt <= '0;
            else if (r_drain_cnt != DRAIN_LAST) r_drain_cnt <= r_drain_cnt + 1'b1;
            if (r_state != SETTLE)               r_settle_cnt <= '0;
            else if (r_settle_cnt != SETTLE_LAST) r_settle_cnt <= r_settle_cnt + 1'b1;
            r_we <= !w_strobe;
            if (w_strobe) begin
                r_addr <= w_head.addr;
                r_data <= w_head.data;
            end
            r_iter <= (w_next_state == RUN);
            r_busy <= is_busy(w_next_state);
            if (w_addr_bad)     r_addr_err <= 1'b1;
            else if (err_clear) r_addr_err <= 1'b0;
            if (w_timeout)      r_tmo_err  <= 1'b1;
            else if (err_clear) r_tmo_err  <= 1'b0;
        end
    end

    assign cmd_ready         = w_ready;
    assign write_enable      = r_we;
    assign reg_addr          = r_addr;
    assign reg_data          = r_data;
    assign iterate_enable    = r_iter;
    assign busy              = r_busy;
    assign addr_err          = r_addr_err;
    assign drain_timeout_err = r_tmo_err;

endmodule
